// File: rtl/flag_cdc_pkg.sv
// Shared constants and helpers for the multi-channel flag/data clock-domain crosser.
// Macro FLAG_CDC_DROP_CNT_EN (in flag_data_cdc) enables the per-channel drop counters.
`timescale 1ns/1ps
package flag_cdc_pkg;

  localparam int SYNC_MIN   = 2;
  localparam int SYNC_MAX   = 4;
  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Low bit index of a channel's slice inside a flattened per-channel bus.
  function automatic int chLo(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/flag_cdc_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset.
`timescale 1ns/1ps
module flag_cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] syncQ;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) syncQ <= '0;
    else       syncQ <= {syncQ[STAGES-2:0], d};
  end

  assign q = syncQ[STAGES-1];

endmodule

// File: rtl/flag_data_cdc.sv
// Multi-channel toggle-handshake crosser: flag pulse plus payload from clkA to clkB, ack back to clkA.
// Define FLAG_CDC_DROP_CNT_EN to add the saturating dropped-flag counters and the drop_cnt_a port.
`timescale 1ns/1ps
module flag_data_cdc
  import flag_cdc_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clkA,
  input  logic                         rstA,
  input  logic                         clkB,
  input  logic                         rstB,
  input  logic [CHANNELS-1:0]          flag_in_a,
  input  logic [CHANNELS*DATA_W-1:0]   data_in_a,
  output logic [CHANNELS-1:0]          busy_a,
  output logic [CHANNELS-1:0]          done_a,
  output logic [CHANNELS-1:0]          flag_out_b,
  output logic [CHANNELS*DATA_W-1:0]   data_out_b
`ifdef FLAG_CDC_DROP_CNT_EN
  ,
  output logic [CHANNELS*DROP_CNT_W-1:0] drop_cnt_a
`endif
);

  generate
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : gBadSync
      $error("flag_data_cdc: SYNC_STAGES=%0d outside legal range %0d..%0d",
             SYNC_STAGES, SYNC_MIN, SYNC_MAX);
    end
  endgenerate

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : gChan
    logic              togA;
    logic              ackA;
    logic              busyQ;
    logic              doneQ;
    logic              accept;
    logic [DATA_W-1:0] holdA;
    logic              reqB;
    logic              histB;
    logic              flagQ;
    logic [DATA_W-1:0] dataQ;

    // busy is purely register-derived so it can gate accept without a combinational path from flag_in_a
    assign busy_a[ch] = togA ^ ackA;
    assign accept     = flag_in_a[ch] & ~busy_a[ch];

    always_ff @(posedge clkA or posedge rstA) begin
      if (rstA) begin
        togA  <= 1'b0;
        holdA <= '0;
        busyQ <= 1'b0;
        doneQ <= 1'b0;
      end else begin
        busyQ <= busy_a[ch];
        doneQ <= busyQ & ~busy_a[ch];
        if (accept) begin
          togA  <= ~togA;
          holdA <= data_in_a[chLo(ch, DATA_W) +: DATA_W];
        end
      end
    end

    assign done_a[ch] = doneQ;

    flag_cdc_sync #(.STAGES(SYNC_STAGES)) reqSync (
      .clock (clkB),
      .reset (rstB),
      .d     (togA),
      .q     (reqB)
    );

    flag_cdc_sync #(.STAGES(SYNC_STAGES)) ackSync (
      .clock (clkA),
      .reset (rstA),
      .d     (histB),
      .q     (ackA)
    );

    // holdA is frozen while busy, so it is stable by the time the toggle edge is seen here
    always_ff @(posedge clkB or posedge rstB) begin
      if (rstB) begin
        histB <= 1'b0;
        flagQ <= 1'b0;
        dataQ <= '0;
      end else begin
        histB <= reqB;
        flagQ <= reqB ^ histB;
        if (reqB ^ histB) dataQ <= holdA;
      end
    end

    assign flag_out_b[ch]                       = flagQ;
    assign data_out_b[chLo(ch, DATA_W) +: DATA_W] = dataQ;

`ifdef FLAG_CDC_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] dropQ;

    always_ff @(posedge clkA or posedge rstA) begin
      if (rstA) begin
        dropQ <= '0;
      end else if (flag_in_a[ch] && busy_a[ch] && (dropQ != DROP_CNT_MAX)) begin
        dropQ <= dropQ + 1'b1;
      end
    end

    assign drop_cnt_a[chLo(ch, DROP_CNT_W) +: DROP_CNT_W] = dropQ;
`endif
  end

endmodule
